// File: rtl/ins_mem.sv
`default_nettype none
// ============================================================================
// Module   : ins_mem
// Brief    : RISC-V memory-access stage. Runs word loads/stores on a
//            req/ready data-memory port, stalls the pipeline while an
//            access is outstanding and registers the MEM/WB outputs.
// Revision : 1.0 - initial release
// ============================================================================
module ins_mem #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ex_pc_plus_4_in,
    input  logic [31:0] ex_alu_result_in,
    input  logic [31:0] ex_read_data2_in,
    input  logic [4:0]  ex_rd_addr_in,
    input  logic        ex_mem_read_in,
    input  logic        ex_mem_write_in,
    input  logic        ex_reg_write_in,
    input  logic        ex_mem_to_reg_in,
    output logic        dmem_req_out,
    output logic        dmem_we_out,
    output logic [31:0] dmem_addr_out,
    output logic [31:0] dmem_wdata_out,
    input  logic        dmem_ready_in,
    input  logic [31:0] dmem_rdata_in,
    output logic        mem_stall_out,
    output logic [31:0] mem_forward_data_out,
    output logic [31:0] wb_pc_plus_4_out,
    output logic [31:0] wb_alu_result_out,
    output logic [31:0] wb_mem_data_out,
    output logic [4:0]  wb_rd_addr_out,
    output logic        wb_reg_write_out,
    output logic        wb_mem_to_reg_out,
    output logic        mem_misaligned_out,
    output logic        mem_timeout_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Last counter value before the access is abandoned.
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;

    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_we;
    logic [7:0]  r_cnt;
    logic        r_abort;
    logic [31:0] r_capt;

    logic [31:0] r_wb_pc4;
    logic [31:0] r_wb_alu;
    logic [31:0] r_wb_mem;
    logic [4:0]  r_wb_rd;
    logic        r_wb_rw;
    logic        r_wb_m2r;
    logic        r_mis;
    logic        r_to;

    logic        w_access;
    logic        w_misaligned;
    logic        w_start;
    logic        w_timeout_hit;

    // A read+write combination is handled as a store (r_we follows write).
    assign w_access      = ex_mem_read_in | ex_mem_write_in;
    assign w_misaligned  = w_access & (ex_alu_result_in[1:0] != 2'b00);
    assign w_start       = w_access & ~w_misaligned;
    assign w_timeout_hit = ~dmem_ready_in & (r_cnt == c_TO_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_WAIT;
            S_WAIT:  if (dmem_ready_in || w_timeout_hit) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Bus request and pipeline stall, decoded from state (drops at once on reset).
    always_comb begin
        dmem_req_out  = 1'b0;
        mem_stall_out = 1'b0;
        case (r_state)
            S_IDLE: mem_stall_out = w_start;
            S_WAIT: begin
                dmem_req_out  = 1'b1;
                mem_stall_out = 1'b1;
            end
            default: begin
                dmem_req_out  = 1'b0;
                mem_stall_out = 1'b0;
            end
        endcase
    end

    // Request latch, wait counter, read-data capture and abort flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
            r_cnt   <= 8'd0;
            r_abort <= 1'b0;
            r_capt  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_addr  <= {ex_alu_result_in[31:2], 2'b00};
                        r_wdata <= ex_read_data2_in;
                        r_we    <= ex_mem_write_in;
                        r_cnt   <= 8'd0;
                        r_abort <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (dmem_ready_in) begin
                        r_capt <= r_we ? 32'd0 : dmem_rdata_in;
                    end else if (w_timeout_hit) begin
                        r_capt  <= 32'd0;
                        r_abort <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE:  r_abort <= 1'b0;
                default: r_abort <= 1'b0;
            endcase
        end
    end

    // MEM/WB register plus misaligned/timeout pulses; stalled cycles load a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb_pc4 <= 32'd0;
            r_wb_alu <= 32'd0;
            r_wb_mem <= 32'd0;
            r_wb_rd  <= 5'd0;
            r_wb_rw  <= 1'b0;
            r_wb_m2r <= 1'b0;
            r_mis    <= 1'b0;
            r_to     <= 1'b0;
        end else begin
            r_mis <= 1'b0;
            r_to  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_wb_rw <= 1'b0;
                    end else begin
                        r_wb_pc4 <= ex_pc_plus_4_in;
                        r_wb_alu <= ex_alu_result_in;
                        r_wb_mem <= 32'd0;
                        r_wb_rd  <= ex_rd_addr_in;
                        r_wb_rw  <= ex_reg_write_in & ~w_misaligned;
                        r_wb_m2r <= ex_mem_to_reg_in;
                        r_mis    <= w_misaligned;
                    end
                end
                S_DONE: begin
                    r_wb_pc4 <= ex_pc_plus_4_in;
                    r_wb_alu <= ex_alu_result_in;
                    r_wb_mem <= r_capt;
                    r_wb_rd  <= ex_rd_addr_in;
                    r_wb_rw  <= ex_reg_write_in & ~r_abort;
                    r_wb_m2r <= ex_mem_to_reg_in;
                    r_to     <= r_abort;
                end
                default: r_wb_rw <= 1'b0;
            endcase
        end
    end

    assign dmem_we_out          = r_we;
    assign dmem_addr_out        = r_addr;
    assign dmem_wdata_out       = r_wdata;
    assign mem_forward_data_out = ex_alu_result_in;
    assign wb_pc_plus_4_out     = r_wb_pc4;
    assign wb_alu_result_out    = r_wb_alu;
    assign wb_mem_data_out      = r_wb_mem;
    assign wb_rd_addr_out       = r_wb_rd;
    assign wb_reg_write_out     = r_wb_rw;
    assign wb_mem_to_reg_out    = r_wb_m2r;
    assign mem_misaligned_out   = r_mis;
    assign mem_timeout_out      = r_to;

endmodule
`default_nettype wire

// File: tb/tb_ins_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_mem
// Brief    : Scoreboard bench for ins_mem. The driver issues instructions,
//            plays the data memory and pushes expected MEM/WB contents; a
//            monitor pops and compares whenever an instruction retires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ins_mem;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ex_pc_plus_4_in = '0;
    logic [31:0] ex_alu_result_in = '0;
    logic [31:0] ex_read_data2_in = '0;
    logic [4:0]  ex_rd_addr_in = '0;
    logic        ex_mem_read_in = 1'b0;
    logic        ex_mem_write_in = 1'b0;
    logic        ex_reg_write_in = 1'b0;
    logic        ex_mem_to_reg_in = 1'b0;
    logic        dmem_req_out;
    logic        dmem_we_out;
    logic [31:0] dmem_addr_out;
    logic [31:0] dmem_wdata_out;
    logic        dmem_ready_in = 1'b0;
    logic [31:0] dmem_rdata_in = '0;
    logic        mem_stall_out;
    logic [31:0] mem_forward_data_out;
    logic [31:0] wb_pc_plus_4_out;
    logic [31:0] wb_alu_result_out;
    logic [31:0] wb_mem_data_out;
    logic [4:0]  wb_rd_addr_out;
    logic        wb_reg_write_out;
    logic        wb_mem_to_reg_out;
    logic        mem_misaligned_out;
    logic        mem_timeout_out;

    ins_mem #(.TIMEOUT_CYCLES(8)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .ex_pc_plus_4_in      (ex_pc_plus_4_in),
        .ex_alu_result_in     (ex_alu_result_in),
        .ex_read_data2_in     (ex_read_data2_in),
        .ex_rd_addr_in        (ex_rd_addr_in),
        .ex_mem_read_in       (ex_mem_read_in),
        .ex_mem_write_in      (ex_mem_write_in),
        .ex_reg_write_in      (ex_reg_write_in),
        .ex_mem_to_reg_in     (ex_mem_to_reg_in),
        .dmem_req_out         (dmem_req_out),
        .dmem_we_out          (dmem_we_out),
        .dmem_addr_out        (dmem_addr_out),
        .dmem_wdata_out       (dmem_wdata_out),
        .dmem_ready_in        (dmem_ready_in),
        .dmem_rdata_in        (dmem_rdata_in),
        .mem_stall_out        (mem_stall_out),
        .mem_forward_data_out (mem_forward_data_out),
        .wb_pc_plus_4_out     (wb_pc_plus_4_out),
        .wb_alu_result_out    (wb_alu_result_out),
        .wb_mem_data_out      (wb_mem_data_out),
        .wb_rd_addr_out       (wb_rd_addr_out),
        .wb_reg_write_out     (wb_reg_write_out),
        .wb_mem_to_reg_out    (wb_mem_to_reg_out),
        .mem_misaligned_out   (mem_misaligned_out),
        .mem_timeout_out      (mem_timeout_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] mdata;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        mis;
        logic        to;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic issued = 1'b0;
    logic pend = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: an issued instruction retires in the first cycle with stall low;
    // its MEM/WB contents are visible one cycle later.
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got retirement expected none");
            end else begin
                e = q.pop_front();
                chk("wb_pc_plus_4",  64'(wb_pc_plus_4_out),   64'(e.pc4));
                chk("wb_alu_result", 64'(wb_alu_result_out),  64'(e.alu));
                chk("wb_mem_data",   64'(wb_mem_data_out),    64'(e.mdata));
                chk("wb_rd_addr",    64'(wb_rd_addr_out),     64'(e.rd));
                chk("wb_reg_write",  64'(wb_reg_write_out),   64'(e.rw));
                chk("wb_mem_to_reg", 64'(wb_mem_to_reg_out),  64'(e.m2r));
                chk("misaligned",    64'(mem_misaligned_out), 64'(e.mis));
                chk("timeout",       64'(mem_timeout_out),    64'(e.to));
            end
        end
        pend = issued && !mem_stall_out && !rst;
        if (pend) issued = 1'b0;
    end

    // Issue one instruction, act as memory (ready on req cycle number ready_at,
    // -1 = never) and check the bus and stall behaviour.
    task automatic run(input string tag,
                       input logic [31:0] pc4, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic rdn, input logic wrn,
                       input logic rw, input logic m2r,
                       input int ready_at, input logic [31:0] rdata,
                       input logic [31:0] e_mdata, input logic e_rw,
                       input logic e_mis, input logic e_to, input logic e_we,
                       input int e_stall, input int e_req);
        exp_t e;
        int   ns = 0;
        int   nr = 0;
        logic done = 1'b0;
        @(posedge clk);
        #1;
        ex_pc_plus_4_in  = pc4;
        ex_alu_result_in = alu;
        ex_read_data2_in = wd;
        ex_rd_addr_in    = rd;
        ex_mem_read_in   = rdn;
        ex_mem_write_in  = wrn;
        ex_reg_write_in  = rw;
        ex_mem_to_reg_in = m2r;
        e.pc4 = pc4; e.alu = alu; e.mdata = e_mdata; e.rd = rd;
        e.rw = e_rw; e.m2r = m2r; e.mis = e_mis; e.to = e_to;
        q.push_back(e);
        issued = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            dmem_ready_in = 1'b0;
            if (k == 0) chk({tag, "_fwd"}, 64'(mem_forward_data_out), 64'(alu));
            if (!mem_stall_out) begin
                done = 1'b1;
                break;
            end
            ns++;
            if (dmem_req_out) begin
                chk({tag, "_bus"}, {dmem_addr_out, dmem_wdata_out},
                    {alu[31:2], 2'b00, wd});
                chk({tag, "_we"}, 64'(dmem_we_out), 64'(e_we));
                if (nr == ready_at) begin
                    dmem_ready_in = 1'b1;
                    dmem_rdata_in = rdata;
                end
                nr++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_retire: got stall stuck expected release", tag);
        end
        chk({tag, "_stall_cycles"}, 64'(ns), 64'(e_stall));
        chk({tag, "_req_cycles"},   64'(nr), 64'(e_req));
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb", {wb_pc_plus_4_out, wb_alu_result_out}, 64'd0);
        chk("rst_wb2", {27'd0, wb_mem_data_out, wb_rd_addr_out},
            64'd0);
        chk("rst_ctl", {58'd0, wb_reg_write_out, wb_mem_to_reg_out, mem_misaligned_out,
            mem_timeout_out, dmem_req_out, mem_stall_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU op, no access.
        run("alu", 32'h104, 32'h123, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0,
            -1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        // Zero-wait load.
        run("ld0", 32'h108, 32'h1004, 32'h77, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1,
            0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1);
        // Store with three wait cycles.
        run("st3", 32'h10C, 32'h2008, 32'hCAFEF00D, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0,
            3, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 5, 4);
        // Misaligned load.
        run("mis", 32'h110, 32'h1002, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1,
            -1, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        // Load that never completes: aborted after 8 request cycles.
        run("tmo", 32'h114, 32'h3000, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1,
            -1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 9, 8);
        // Read+write together behaves as a store; low address bits dropped? no, aligned.
        run("rdwr", 32'h118, 32'h40, 32'hA5A5A5A5, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0,
            1, 32'h55, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 3, 2);
        // Write to x0 passes through unchanged.
        run("x0", 32'h11C, 32'hFFFF0000, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
            -1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Asynchronous reset in the second WAIT cycle of a load.
        @(posedge clk);
        #1;
        ex_pc_plus_4_in  = 32'h120;
        ex_alu_result_in = 32'h1004;
        ex_rd_addr_in    = 5'd3;
        ex_mem_read_in   = 1'b1;
        ex_mem_write_in  = 1'b0;
        ex_reg_write_in  = 1'b1;
        ex_mem_to_reg_in = 1'b1;
        dmem_ready_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mid_req_before", 64'(dmem_req_out), 64'd1);
        rst = 1'b1;
        ex_mem_read_in  = 1'b0;
        ex_reg_write_in = 1'b0;
        #1;
        chk("rst_mid_ctl", {62'd0, dmem_req_out, mem_stall_out}, 64'd0);
        chk("rst_mid_wb", {wb_pc_plus_4_out, wb_alu_result_out}, 64'd0);
        chk("rst_mid_wb2", {25'd0, wb_mem_data_out, wb_rd_addr_out, wb_reg_write_out,
            wb_mem_to_reg_out}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Following ALU op completes in one cycle.
        run("alu2", 32'h204, 32'h456, 32'h0, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0,
            -1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
